// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed 7-segment driver: deglitched slot writes from a
// register-read bus, and a blank/show scan with registered physical outputs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_BLANK | all digits and segments off; counts BLANK_CYCLES before SHOW
// ST_SHOW  | digit idx lit with slot[idx]; counts DWELL_CYCLES, then advance
module seg7_scan_mux #(
    parameter int unsigned DWELL_CYCLES   = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] code7_readdata,
    input  logic [3:0] dig_sel_readdata,
    input  logic       scan_en,
    output logic [7:0] seg_out,
    output logic [3:0] dig_out,
    output logic       frame_tick
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [23:0] DWELL_LAST = 24'(DWELL_CYCLES - 1);
    localparam logic [23:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 24'd0 : 24'(BLANK_CYCLES - 1);
    localparam logic [7:0]  SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0]  DIG_OFF    = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [7:0] s_code;
    logic [3:0] s_dig;
    logic [7:0] lc_code;
    logic [3:0] lc_dig;
    logic [7:0] slot [4];
    logic       commit;

    state_t      state;
    state_t      state_d;
    logic [23:0] cnt;
    logic [23:0] cnt_d;
    logic [1:0]  idx;
    logic [1:0]  idx_d;

    logic [7:0] seg_d;
    logic [3:0] dig_d;
    logic       tick_d;

    // A pair must be seen on two consecutive edges before it is written.
    assign commit = (code7_readdata == s_code) && (dig_sel_readdata == s_dig) &&
                    ((code7_readdata != lc_code) || (dig_sel_readdata != lc_dig));

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            s_code  <= 8'h00;
            s_dig   <= 4'h0;
            lc_code <= 8'h00;
            lc_dig  <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= 8'h00;
            end
        end else begin
            s_code <= code7_readdata;
            s_dig  <= dig_sel_readdata;
            if (commit) begin
                lc_code <= code7_readdata;
                lc_dig  <= dig_sel_readdata;
                for (int i = 0; i < 4; i++) begin
                    if (dig_sel_readdata[i]) begin
                        slot[i] <= code7_readdata;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 24'd1;
        idx_d   = idx;
        if (!scan_en) begin
            state_d = ST_BLANK;
            cnt_d   = 24'd0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = 24'd0;
                    end
                end
                ST_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        idx_d   = idx + 2'd1;
                        cnt_d   = 24'd0;
                        state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = 24'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it;
    // slot is read pre-commit, giving one extra edge of write-to-display.
    always_comb begin
        seg_d  = SEG_OFF;
        dig_d  = DIG_OFF;
        tick_d = 1'b0;
        if (state_d == ST_SHOW) begin
            seg_d  = SEG_ACTIVE_LOW ? ~slot[idx_d] : slot[idx_d];
            dig_d  = DIG_ACTIVE_LOW ? ~(4'b0001 << idx_d) : (4'b0001 << idx_d);
            tick_d = (idx_d == 2'd3) && (cnt_d == DWELL_LAST);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state      <= ST_BLANK;
            cnt        <= 24'd0;
            idx        <= 2'd0;
            seg_out    <= SEG_OFF;
            dig_out    <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            seg_out    <= seg_d;
            dig_out    <= dig_d;
            frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with DWELL_CYCLES=4, BLANK_CYCLES=2: a 6-cycle digit
// period, 24-cycle frame, slot writes visible three edges after the inputs change.
module tb_seg7_scan_mux;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic [7:0] code7_readdata = 8'h00;
    logic [3:0] dig_sel_readdata = 4'h0;
    logic       scan_en = 1'b0;
    logic [7:0] seg_out;
    logic [3:0] dig_out;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int j = 0;
    int pend_cnt = 0;
    bit dark = 1'b1;
    logic [7:0] m_slot [4];
    logic [7:0] pend [4];

    typedef struct {
        logic [7:0] code;
        logic [3:0] sel;
        int         hold;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    always #5 clk_clk = ~clk_clk;

    seg7_scan_mux #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .code7_readdata(code7_readdata),
        .dig_sel_readdata(dig_sel_readdata),
        .scan_en(scan_en),
        .seg_out(seg_out),
        .dig_out(dig_out),
        .frame_tick(frame_tick)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at j=%0d: actual=%h required=%h", name, j, act, exp);
        end
    endtask

    // j = cycles since reset release; phase 0,1 blank, 2..5 show digit (j/6)%4.
    task automatic check_outputs();
        int ph;
        int dg;
        logic [7:0] es;
        logic [3:0] ed;
        logic [3:0] one;
        logic       et;
        ph = j % 6;
        dg = (j / 6) % 4;
        es = 8'hFF;
        ed = 4'hF;
        et = 1'b0;
        if (!dark && ph >= 2) begin
            one = 4'b0001 << dg;
            es  = ~m_slot[dg];
            ed  = ~one;
            et  = ((j % 24) == 23);
        end
        check("seg_out", seg_out, es);
        check("dig_out", {4'h0, dig_out}, {4'h0, ed});
        check("frame_tick", {7'h0, frame_tick}, {7'h0, et});
    endtask

    task automatic step();
        @(posedge clk_clk);
        @(negedge clk_clk);
        j++;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                for (int i = 0; i < 4; i++) m_slot[i] = pend[i];
            end
        end
        check_outputs();
    endtask

    task automatic wait_show(input int dg, input int ph);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (((j / 6) % 4) == dg && (j % 6) == ph) found = 1'b1;
            else step();
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_show digit %0d phase %0d: actual=timeout required=reached", dg, ph);
        end
    endtask

    initial begin
        vecs[0]  = '{8'h00, 4'b0000, 30, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{8'h3F, 4'b0001, 30, 8'h3F, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{8'h06, 4'b1010, 30, 8'h3F, 8'h06, 8'h00, 8'h06};
        vecs[3]  = '{8'h7F, 4'b1111,  1, 8'h3F, 8'h06, 8'h00, 8'h06};
        vecs[4]  = '{8'h06, 4'b1010, 10, 8'h3F, 8'h06, 8'h00, 8'h06};
        vecs[5]  = '{8'h5B, 4'b0100, 26, 8'h3F, 8'h06, 8'h5B, 8'h06};
        vecs[6]  = '{8'h66, 4'b0000, 10, 8'h3F, 8'h06, 8'h5B, 8'h06};
        vecs[7]  = '{8'h11, 4'b0001,  1, 8'h3F, 8'h06, 8'h5B, 8'h06};
        vecs[8]  = '{8'h22, 4'b0010,  1, 8'h3F, 8'h06, 8'h5B, 8'h06};
        vecs[9]  = '{8'h11, 4'b0001,  1, 8'h3F, 8'h06, 8'h5B, 8'h06};
        vecs[10] = '{8'h22, 4'b0010,  1, 8'h3F, 8'h06, 8'h5B, 8'h06};
        vecs[11] = '{8'h6D, 4'b1111, 30, 8'h6D, 8'h6D, 8'h6D, 8'h6D};
        for (int i = 0; i < 4; i++) begin
            m_slot[i] = 8'h00;
            pend[i]   = 8'h00;
        end

        // reset state
        dark = 1'b1;
        for (int n = 0; n < 3; n++) step();
        reset_reset_n = 1'b1;
        scan_en = 1'b1;
        dark = 1'b0;
        j = 0;

        // table: each row held for 'hold' cycles, new slots expected 3 edges later
        for (int v = 0; v < NV; v++) begin
            code7_readdata   = vecs[v].code;
            dig_sel_readdata = vecs[v].sel;
            pend[0] = vecs[v].s0;
            pend[1] = vecs[v].s1;
            pend[2] = vecs[v].s2;
            pend[3] = vecs[v].s3;
            pend_cnt = 3;
            for (int n = 0; n < vecs[v].hold; n++) step();
        end

        // scan_en dropped mid-SHOW of digit 2; a write lands while dark
        wait_show(2, 3);
        scan_en = 1'b0;
        dark = 1'b1;
        code7_readdata   = 8'h4F;
        dig_sel_readdata = 4'b0100;
        for (int i = 0; i < 4; i++) pend[i] = m_slot[i];
        pend[2] = 8'h4F;
        pend_cnt = 3;
        for (int n = 0; n < 5; n++) step();
        scan_en = 1'b1;
        check_outputs();
        dark = 1'b0;
        j = 12;
        for (int n = 0; n < 14; n++) step();

        // reset mid-SHOW with slots loaded
        wait_show(2, 3);
        reset_reset_n = 1'b0;
        code7_readdata   = 8'h00;
        dig_sel_readdata = 4'h0;
        dark = 1'b1;
        pend_cnt = 0;
        for (int n = 0; n < 3; n++) step();
        reset_reset_n = 1'b1;
        dark = 1'b0;
        j = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
        for (int n = 0; n < 8; n++) step();

        // write latency into the slot just coming on screen
        code7_readdata   = 8'h39;
        dig_sel_readdata = 4'b0010;
        for (int i = 0; i < 4; i++) pend[i] = 8'h00;
        pend[1] = 8'h39;
        pend_cnt = 3;
        for (int n = 0; n < 3; n++) step();
        check("latency_slot1", seg_out, 8'hC6);
        for (int n = 0; n < 20; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 50000: clock cycles each digit is lit; legal range 1..2^24-1.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 500: all-off cycles before each digit; legal range 0..2^24-1; 0 skips the blank phase.
REQ-003 The block SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 drives lit segments as 0 on seg_out.
REQ-004 The block SHALL have parameter DIG_ACTIVE_LOW, default 1: 1 drives the enabled digit as 0 on dig_out.
REQ-005 clk_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_reset_n  in  1  reset; synchronous and active-low.
REQ-007 code7_readdata  in  8  segment pattern {dp,g,f,e,d,c,b,a}, 1 = lit (logical).
REQ-008 dig_sel_readdata  in  4  digit-slot write mask; bit i selects slot i.
REQ-009 scan_en  in  1  1 = scanning; 0 = display dark.
REQ-010 seg_out  out  8  physical segment drive, polarity per SEG_ACTIVE_LOW.
REQ-011 dig_out  out  4  physical digit enables, polarity per DIG_ACTIVE_LOW; at most one digit enabled.
REQ-012 frame_tick  out  1  one-cycle pulse marking end of a full 4-digit frame.

Function
REQ-013 Input capture SHALL register code7_readdata and dig_sel_readdata every cycle into a sample pair (s_code, s_dig).
REQ-014 Commit SHALL occur on an edge where live inputs equal (s_code, s_dig) and differ from the last-committed pair; commit writes live code7 into every slot i with dig_sel bit i set and updates last-committed pair.
REQ-015 dig_sel = 0 on a commit SHALL update last-committed pair only; no slot changes.
REQ-016 Inputs changing every cycle SHALL never commit; a single-cycle glitch SHALL never reach a slot.
REQ-017 Latency: inputs stable from after edge 0 SHALL be sampled at edge 1, committed at edge 2, visible on seg_out at edge 3 if that slot is being shown.
REQ-018 Scan FSM SHALL have states BLANK and SHOW, a 24-bit phase counter, and a 2-bit digit index idx.
REQ-019 BLANK SHALL last BLANK_CYCLES cycles with all digits off and all segments off, then go to SHOW with counter cleared.
REQ-020 SHOW SHALL last DWELL_CYCLES cycles with only digit idx enabled and seg_out = slot[idx] (polarity applied), then idx increments and state goes to BLANK (or directly SHOW of next digit when BLANK_CYCLES = 0).
REQ-021 idx SHALL wrap 3 -> 0.
REQ-022 frame_tick SHALL be 1 exactly on the last SHOW cycle of idx 3, else 0.
REQ-023 A commit to the slot currently shown SHALL update seg_out without restarting dwell or changing idx.
REQ-024 scan_en = 0 SHALL force state BLANK, counter 0, idx held, frame_tick 0, outputs off from the next edge; slot capture/commit continues.
REQ-025 On scan_en 0 -> 1 the FSM SHALL start with a full BLANK phase for the held idx.
REQ-026 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-027 While reset_reset_n = 0 at an edge: slots = 0, sample and last-committed pairs = 0, state BLANK, counter 0, idx 0, frame_tick 0.
REQ-028 During and after reset seg_out and dig_out SHALL be at off level (defaults: seg_out = 8'hFF, dig_out = 4'hF).
REQ-029 Reset asserted mid-SHOW SHALL take precedence over all events and darken the display at that edge.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2, defaults otherwise)
REQ-030 Reset, scan_en=1, no writes -> dig_out cycles 1110,1101,1011,0111 each 4 cycles separated by 2 cycles of 1111; seg_out stays FF; frame_tick every 24 cycles.
REQ-031 code7=8'h3F, dig_sel=4'b0001 held -> slot0 committed at 2nd edge; seg_out=8'hC0 whenever dig_out=1110; other digits FF.
REQ-032 code7=8'h06 with dig_sel=4'b1010 -> digits 1 and 3 show 8'hF9; digits 0 and 2 unchanged.
REQ-033 One-cycle glitch code7=8'h7F between stable values -> no slot changes the glitch value; seg_out never F... shows 8'h80.
REQ-034 scan_en dropped mid-SHOW of idx 2 -> dig_out=1111 next edge; re-enable -> 2 blank cycles then idx 2 shown for 4 cycles.
REQ-035 Reset pulsed mid-SHOW with slots loaded -> outputs FF/F, slots cleared, scan restarts at idx 0 after BLANK.
